// File: rtl/adc_frame_scheduler_pkg.sv
// adc_frame_scheduler_pkg
//   Shared definitions for the ADC frame scheduler: default parameter
//   values and the encoding of the acquisition FSM states.
package adc_frame_scheduler_pkg;

  localparam int FRAME_LEN_DEF  = 64;    // samples per FFT frame
  localparam int SAMPLE_DIV_DEF = 1000;  // clock cycles per sample period
  localparam int DATA_W_DEF     = 16;    // ADC sample width

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_CONVERT   = 2'd2,
    ST_STORE     = 2'd3
  } state_t;

endpackage

// File: rtl/adc_frame_scheduler_sample_tick_gen.sv
// sample_tick_gen
//   Sample-period counter. Counts 0..SAMPLE_DIV-1 while enable is high and
//   wraps; held at 0 while enable is low. tick is high while the count sits
//   at its last value, i.e. once per sample period.
// Ports:
//   clk    in  system clock (rising edge)
//   rst    in  synchronous active-high reset
//   enable in  run the counter
//   tick   out one cycle per SAMPLE_DIV cycles (decoded from the count flop)
module sample_tick_gen
  import adc_frame_scheduler_pkg::*;
#(
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!enable) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler
//   Periodically requests ADC conversions, writes each returned sample into
//   a ping-pong frame buffer and publishes completed banks to the FFT.
//
// Handshakes (all single-cycle strobes, no back-pressure):
//   ADC_START -> ADC reader; ADC_DV/ADC_DATA <- reader, accepted only in
//   CONVERT. FRAME_READY/FRAME_BANK are a level held until a FRAME_ACK
//   pulse arrives while FRAME_READY is high; an ACK in the same cycle as a
//   frame completion is applied first, so the new frame is published.
//
// Ports:
//   CLOCK, RESET        clock, synchronous active-high reset
//   ENABLE              run periodic acquisition
//   ADC_START           one-cycle conversion request
//   ADC_DATA, ADC_DV    sample and its valid strobe
//   WR_EN/BANK/ADDR/DATA frame-buffer write port
//   FRAME_READY/BANK    completed bank waiting for the FFT
//   FRAME_ACK           FFT has consumed FRAME_BANK
//   OVERRUN             sticky: missed tick or unacknowledged frame overwritten
//   DBG_STATE           current FSM state (debug)
//   Every output is a flop or a decode of flops only.
module adc_frame_scheduler
  import adc_frame_scheduler_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  localparam int AW        = $clog2(FRAME_LEN)
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              ENABLE,
  output logic              ADC_START,
  input  logic [DATA_W-1:0] ADC_DATA,
  input  logic              ADC_DV,
  output logic              WR_EN,
  output logic              WR_BANK,
  output logic [AW-1:0]     WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              FRAME_READY,
  output logic              FRAME_BANK,
  input  logic              FRAME_ACK,
  output logic              OVERRUN,
  output logic [1:0]        DBG_STATE
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

  logic tick;

  sample_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk   (CLOCK),
    .rst   (RESET),
    .enable(ENABLE),
    .tick  (tick)
  );

  state_t              state_q, state_d;
  logic                start_q, start_d;
  logic                wr_bank_q, wr_bank_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                ready_q, ready_d;
  logic                frame_bank_q, frame_bank_d;
  logic                overrun_q, overrun_d;

  always_comb begin
    state_d      = state_q;
    start_d      = 1'b0;
    wr_bank_d    = wr_bank_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    ready_d      = ready_q;
    frame_bank_d = frame_bank_q;
    overrun_d    = overrun_q;

    // ACK is applied before any completion in the same cycle.
    if (FRAME_ACK && ready_q) begin
      ready_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (ENABLE) begin
          state_d = ST_WAIT_TICK;
        end
      end

      ST_WAIT_TICK: begin
        if (!ENABLE) begin
          state_d   = ST_IDLE;
          wr_addr_d = '0;
        end else if (tick) begin
          start_d = 1'b1;
          state_d = ST_CONVERT;
        end
      end

      ST_CONVERT: begin
        // A tick here cannot be serviced: flag it, do not re-request.
        if (tick) begin
          overrun_d = 1'b1;
        end
        if (ADC_DV) begin
          wr_data_d = ADC_DATA;
          state_d   = ST_STORE;
        end
      end

      ST_STORE: begin
        if (tick) begin
          overrun_d = 1'b1;
        end
        // FRAME_LEN is a power of two, so the increment wraps on its own.
        wr_addr_d = wr_addr_q + 1'b1;
        if (wr_addr_q == LAST_ADDR) begin
          if (ready_q && !FRAME_ACK) begin
            // FFT still owns the previous frame: rewrite the same bank.
            overrun_d = 1'b1;
          end else begin
            ready_d      = 1'b1;
            frame_bank_d = wr_bank_q;
            wr_bank_d    = ~wr_bank_q;
          end
        end
        if (ENABLE) begin
          state_d = ST_WAIT_TICK;
        end else begin
          // Leaving acquisition discards the partial frame.
          state_d   = ST_IDLE;
          wr_addr_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      wr_bank_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      ready_q      <= 1'b0;
      frame_bank_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      wr_bank_q    <= wr_bank_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      ready_q      <= ready_d;
      frame_bank_q <= frame_bank_d;
      overrun_q    <= overrun_d;
    end
  end

  assign ADC_START   = start_q;
  assign WR_EN       = (state_q == ST_STORE);
  assign WR_BANK     = wr_bank_q;
  assign WR_ADDR     = wr_addr_q;
  assign WR_DATA     = wr_data_q;
  assign FRAME_READY = ready_q;
  assign FRAME_BANK  = frame_bank_q;
  assign OVERRUN     = overrun_q;
  assign DBG_STATE   = state_q;

endmodule

// File: doc/adc_frame_scheduler.md
ADC_FRAME_SCHEDULER -- requirements
Module: adc_frame_scheduler

Interface
REQ-001 Parameter FRAME_LEN, default 64, samples per FFT frame; power of two, 4..1024.
REQ-002 Parameter SAMPLE_DIV, default 1000, CLOCK cycles per sample period; at least 64.
REQ-003 Parameter DATA_W, default 16, ADC sample width.
REQ-004 CLOCK  in  1  single system clock; all logic on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 ENABLE  in  1  high = run periodic acquisition.
REQ-007 ADC_START  out  1  one-cycle pulse requesting one conversion from the ADC SPI reader.
REQ-008 ADC_DATA  in  DATA_W  sample from the ADC SPI reader.
REQ-009 ADC_DV  in  1  one-cycle strobe; ADC_DATA valid.
REQ-010 WR_EN  out  1  frame-buffer write strobe.
REQ-011 WR_BANK  out  1  ping-pong bank being written.
REQ-012 WR_ADDR  out  clog2(FRAME_LEN)  write address within the bank.
REQ-013 WR_DATA  out  DATA_W  sample written.
REQ-014 FRAME_READY  out  1  completed bank awaits FFT; held until acknowledged.
REQ-015 FRAME_BANK  out  1  bank index the FFT reads while FRAME_READY is high.
REQ-016 FRAME_ACK  in  1  one-cycle pulse: FFT has consumed FRAME_BANK.
REQ-017 OVERRUN  out  1  sticky error flag; cleared only by RESET.

Function
REQ-018 Tick counter: counts 0..SAMPLE_DIV-1 while ENABLE is high and wraps; it holds at 0 while ENABLE is low; tick = count equals SAMPLE_DIV-1.
REQ-019 FSM states: IDLE, WAIT_TICK, CONVERT, STORE.
REQ-020 IDLE -> WAIT_TICK when ENABLE is high; WAIT_TICK -> IDLE when ENABLE is low.
REQ-021 WAIT_TICK on tick: ADC_START=1 in the next cycle, then CONVERT.
REQ-022 CONVERT on ADC_DV: capture ADC_DATA, then STORE.
REQ-023 STORE: WR_EN=1 for exactly one cycle with WR_DATA=captured sample and current WR_BANK/WR_ADDR; ADC_DV to WR_EN latency is exactly 1 cycle.
REQ-024 After STORE, WR_ADDR increments; go to WAIT_TICK if ENABLE is high, otherwise IDLE.
REQ-025 A tick while in CONVERT or STORE is missed: OVERRUN=1 one cycle later; no extra ADC_START is issued.
REQ-026 Frame complete = STORE at WR_ADDR=FRAME_LEN-1; WR_ADDR wraps to 0 next cycle.
REQ-027 On frame complete with FRAME_READY low (after this cycle's ACK is applied): FRAME_READY=1, FRAME_BANK=WR_BANK, WR_BANK toggles, all next cycle.
REQ-028 On frame complete with FRAME_READY still high: OVERRUN=1; WR_BANK unchanged, so the bank is overwritten; FRAME_READY/FRAME_BANK unchanged.
REQ-029 FRAME_ACK while FRAME_READY is high clears FRAME_READY next cycle; FRAME_ACK while FRAME_READY is low is ignored.
REQ-030 FRAME_ACK and frame complete in the same cycle: ACK takes priority; the new frame is published per REQ-027 with no OVERRUN.
REQ-031 ENABLE low in CONVERT: the conversion completes and is stored; then IDLE.
REQ-032 Entering IDLE because ENABLE is low: WR_ADDR resets to 0, discarding the partial frame; WR_BANK, FRAME_READY and FRAME_BANK are kept.
REQ-033 ADC_DV outside CONVERT is ignored.
REQ-034 No combinational path from any input to any output.

Reset
REQ-035 On RESET: state=IDLE, tick counter=0, ADC_START=0, WR_EN=0, WR_BANK=0, WR_ADDR=0, WR_DATA=0, FRAME_READY=0, FRAME_BANK=0, OVERRUN=0.
REQ-036 RESET mid-conversion abandons the conversion; a late ADC_DV after RESET is ignored per REQ-033.

Structure
REQ-037 The shared package holds the FSM state encoding and the defaults for FRAME_LEN, SAMPLE_DIV and DATA_W.
REQ-038 One sub-module, sample_tick_gen, implements the REQ-018 tick counter; everything else stays in adc_frame_scheduler.

Verification
REQ-039 SAMPLE_DIV=64, FRAME_LEN=4, ADC model responds with DV 20 cycles after START -> ADC_START every 64 cycles; WR_ADDR 0,1,2,3; FRAME_READY=1 with FRAME_BANK=0; WR_BANK=1.
REQ-040 ADC_DV with ADC_DATA=16'hA5C3 -> next cycle WR_EN=1 and WR_DATA=16'hA5C3.
REQ-041 No FRAME_ACK for two frames -> second completion sets OVERRUN=1; FRAME_BANK stays 0; bank 1 is rewritten.
REQ-042 FRAME_ACK coincident with completion of bank 1 -> FRAME_READY stays 1, FRAME_BANK=1, OVERRUN=0.
REQ-043 ADC model delays DV by 70 cycles -> OVERRUN=1 and exactly one ADC_START per conversion.
REQ-044 ENABLE dropped at WR_ADDR=2, then RESET asserted mid-CONVERT -> pending sample stored and WR_ADDR=0 in IDLE; after RESET, all outputs are at their REQ-035 values.
